// File: rtl/axis_bus_sched.sv
// Round-robin scheduler steering a shared AXI-Stream demux across six packet FIFOs.
// Latency: grant one cycle after arbitration; every output is registered.
// Backpressure: a grant holds across tready=0 until the tlast beat or the idle watchdog ends it.
module axis_bus_sched #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] req,
  input  logic       axis_in_tvalid,
  input  logic       axis_in_tready,
  input  logic       axis_in_tlast,
  output logic [7:0] bus_sel,
  output logic       busy,
  output logic       timeout,
  output logic [2:0] last_ch
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  // A limit of zero would never fire, so it behaves as a limit of one.
  localparam logic [15:0] WD_LIM = (TIMEOUT == 16'd0) ? 16'd1 : TIMEOUT;
  localparam logic [15:0] WD_MAX = WD_LIM - 16'd1;

  state_t      state;
  logic [2:0]  rr_ptr;
  logic [15:0] wd;
  logic        pick_vld;
  logic [2:0]  pick_idx;
  logic [2:0]  next_ch;
  logic        beat;

  assign beat    = axis_in_tvalid & axis_in_tready;
  assign next_ch = (last_ch == 3'd5) ? 3'd0 : last_ch + 3'd1;

  // Find the first requesting FIFO at or after rr_ptr, wrapping 5 -> 0; scanning
  // from the farthest offset down lets the nearest requester win.
  always_comb begin
    logic [3:0] cand;
    pick_vld = 1'b0;
    pick_idx = 3'd0;
    cand     = 4'd0;
    for (int i = 5; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (req[cand[2:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[2:0];
      end
    end
  end

  // Scheduler FSM with registered outputs and the per-grant idle watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bus_sel <= 8'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      last_ch <= 3'd0;
      rr_ptr  <= 3'd0;
      wd      <= 16'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          bus_sel <= 8'd0;
          busy    <= 1'b0;
          if (en && pick_vld) begin
            state   <= GRANT;
            bus_sel <= 8'd128 + {5'd0, pick_idx};
            busy    <= 1'b1;
            last_ch <= pick_idx;
            wd      <= 16'd0;
          end
        end
        GRANT: begin
          // en and req are deliberately ignored: a started packet always finishes.
          if (beat) begin
            wd <= 16'd0;
            if (axis_in_tlast) begin
              state   <= GAP;
              bus_sel <= 8'd0;
              busy    <= 1'b0;
              rr_ptr  <= next_ch;
            end
          end else if (wd == WD_MAX) begin
            timeout <= 1'b1;
            state   <= GAP;
            bus_sel <= 8'd0;
            busy    <= 1'b0;
            rr_ptr  <= next_ch;
            wd      <= 16'd0;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        GAP: begin
          state   <= IDLE;
          bus_sel <= 8'd0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          bus_sel <= 8'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_bus_sched.sv
// Directed bench for axis_bus_sched: three instances with TIMEOUT 1024, 8 and 0.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// Each scenario task performs its own inline comparisons.
module tb_axis_bus_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] req;
  logic       tvalid, tready, tlast;

  logic [7:0] bus_sel, bus_sel_w, bus_sel_z;
  logic       busy, busy_w, busy_z;
  logic       timeout, timeout_w, timeout_z;
  logic [2:0] last_ch, last_ch_w, last_ch_z;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axis_bus_sched dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tlast(tlast),
    .bus_sel(bus_sel), .busy(busy), .timeout(timeout), .last_ch(last_ch)
  );

  axis_bus_sched #(.TIMEOUT(16'd8)) dut_w (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tlast(tlast),
    .bus_sel(bus_sel_w), .busy(busy_w), .timeout(timeout_w), .last_ch(last_ch_w)
  );

  axis_bus_sched #(.TIMEOUT(16'd0)) dut_z (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tlast(tlast),
    .bus_sel(bus_sel_z), .busy(busy_z), .timeout(timeout_z), .last_ch(last_ch_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 6'd0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (bus_sel !== 8'd0) $display("FAIL reset_bus_sel got=%0d exp=0", bus_sel); else n_pass++;
    n_chk++; if ({busy, timeout, last_ch} !== 5'd0) $display("FAIL reset_flags got busy=%b timeout=%b last_ch=%0d exp 0/0/0", busy, timeout, last_ch); else n_pass++;
    // Requests with en=0 must not grant.
    req = 6'b000001;
    tick(); tick();
    n_chk++; if (bus_sel !== 8'd0) $display("FAIL idle_en0 got=%0d exp=0", bus_sel); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; req = 6'b000100; tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
    tick();
    n_chk++; if (bus_sel !== 8'd130 || busy !== 1'b1 || last_ch !== 3'd2) $display("FAIL single_grant got sel=%0d busy=%b ch=%0d exp 130/1/2", bus_sel, busy, last_ch); else n_pass++;
    tick();
    n_chk++; if (bus_sel !== 8'd130) $display("FAIL single_beat1 got=%0d exp=130", bus_sel); else n_pass++;
    tick();
    tlast = 1'b1;
    n_chk++; if (bus_sel !== 8'd130) $display("FAIL single_beat2 got=%0d exp=130", bus_sel); else n_pass++;
    tick();
    req = 6'd0; tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if (bus_sel !== 8'd0 || busy !== 1'b0 || last_ch !== 3'd2) $display("FAIL single_gap got sel=%0d busy=%b ch=%0d exp 0/0/2", bus_sel, busy, last_ch); else n_pass++;
    tick();
    n_chk++; if (bus_sel !== 8'd0) $display("FAIL single_idle got=%0d exp=0", bus_sel); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_sel;
    do_reset();
    en = 1'b1; req = 6'b111111; tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
    for (int k = 0; k < 7; k++) begin
      exp_sel = 8'd128 + 8'(k % 6);
      tick();
      n_chk++; if (bus_sel !== exp_sel) $display("FAIL rr_grant%0d got=%0d exp=%0d", k, bus_sel, exp_sel); else n_pass++;
      tick();
      n_chk++; if (bus_sel !== 8'd0) $display("FAIL rr_gap%0d got=%0d exp=0", k, bus_sel); else n_pass++;
      tick();
      n_chk++; if (bus_sel !== 8'd0) $display("FAIL rr_idle%0d got=%0d exp=0", k, bus_sel); else n_pass++;
    end
    req = 6'd0;
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    do_reset();
    en = 1'b1; req = 6'b000001; tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
    tick();
    tick();
    // Stall 20 cycles; drop en and req too, which must not disturb the grant.
    tready = 1'b0; en = 1'b0; req = 6'd0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus_sel !== 8'd128 || timeout !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); else n_pass++;
    tready = 1'b1; tlast = 1'b1;
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if (bus_sel !== 8'd0 || timeout !== 1'b0) $display("FAIL bp_complete got sel=%0d timeout=%b exp 0/0", bus_sel, timeout); else n_pass++;
  endtask

  task automatic test_watchdog();
    int bad;
    bad = 0;
    do_reset();
    en = 1'b1; req = 6'b010000; tvalid = 1'b0; tready = 1'b1;
    tick();
    req = 6'b110000;
    n_chk++; if (bus_sel_w !== 8'd132) $display("FAIL wd_grant got=%0d exp=132", bus_sel_w); else n_pass++;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (bus_sel_w !== 8'd132 || timeout_w !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL wd_hold bad_cycles=%0d exp=0", bad); else n_pass++;
    tick();
    n_chk++; if (timeout_w !== 1'b1 || bus_sel_w !== 8'd0) $display("FAIL wd_abort got timeout=%b sel=%0d exp 1/0", timeout_w, bus_sel_w); else n_pass++;
    tick();
    n_chk++; if (timeout_w !== 1'b0 || bus_sel_w !== 8'd0) $display("FAIL wd_pulse_end got timeout=%b sel=%0d exp 0/0", timeout_w, bus_sel_w); else n_pass++;
    tick();
    req = 6'd0;
    n_chk++; if (bus_sel_w !== 8'd133 || last_ch_w !== 3'd5) $display("FAIL wd_next got sel=%0d ch=%0d exp 133/5", bus_sel_w, last_ch_w); else n_pass++;
  endtask

  task automatic test_coincidence();
    do_reset();
    en = 1'b1; req = 6'b000001; tvalid = 1'b0; tready = 1'b1; tlast = 1'b0;
    tick();
    req = 6'd0;
    // Seven idle cycles bring wd to TIMEOUT-1 for the eighth grant cycle.
    for (int k = 0; k < 7; k++) tick();
    n_chk++; if (bus_sel_w !== 8'd128) $display("FAIL coin_pre got=%0d exp=128", bus_sel_w); else n_pass++;
    tvalid = 1'b1; tlast = 1'b1;
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if (bus_sel_w !== 8'd0 || timeout_w !== 1'b0) $display("FAIL coin_done got sel=%0d timeout=%b exp 0/0", bus_sel_w, timeout_w); else n_pass++;
    tick();
    n_chk++; if (timeout_w !== 1'b0) $display("FAIL coin_after got timeout=%b exp 0", timeout_w); else n_pass++;
  endtask

  task automatic test_timeout_zero();
    do_reset();
    en = 1'b1; req = 6'b000001; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    tick();
    req = 6'd0;
    n_chk++; if (bus_sel_z !== 8'd128) $display("FAIL tz_grant got=%0d exp=128", bus_sel_z); else n_pass++;
    tick();
    n_chk++; if (timeout_z !== 1'b1 || bus_sel_z !== 8'd0) $display("FAIL tz_abort got timeout=%b sel=%0d exp 1/0", timeout_z, bus_sel_z); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; req = 6'b001000; tvalid = 1'b1; tready = 1'b1; tlast = 1'b1;
    tick();
    n_chk++; if (bus_sel !== 8'd131) $display("FAIL ar_first got=%0d exp=131", bus_sel); else n_pass++;
    tick();
    tick();
    tlast = 1'b0;
    tick();
    n_chk++; if (bus_sel !== 8'd131) $display("FAIL ar_second got=%0d exp=131", bus_sel); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (bus_sel !== 8'd0 || busy !== 1'b0) $display("FAIL ar_async got sel=%0d busy=%b exp 0/0", bus_sel, busy); else n_pass++;
    tick();
    rst = 1'b0; req = 6'b101000;
    // rr_ptr was 4 before reset; only a cleared pointer picks FIFO 3 over FIFO 5.
    tick();
    req = 6'd0;
    n_chk++; if (bus_sel !== 8'd131 || last_ch !== 3'd3) $display("FAIL ar_regrant got sel=%0d ch=%0d exp 131/3", bus_sel, last_ch); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_coincidence();
    test_timeout_zero();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
